// File: rtl/hack_kbd_pkg.sv
// Shared constants for the PS/2 -> Hack keyboard input stage.
// Hack key codes, scan set 2 prefix/shift codes, RX state type.
package hack_kbd_pkg;

    // Hack special key codes
    localparam logic [7:0] HACK_SPACE     = 8'd32;
    localparam logic [7:0] HACK_NEWLINE   = 8'd128;
    localparam logic [7:0] HACK_BACKSPACE = 8'd129;
    localparam logic [7:0] HACK_LEFT      = 8'd130;
    localparam logic [7:0] HACK_UP        = 8'd131;
    localparam logic [7:0] HACK_RIGHT     = 8'd132;
    localparam logic [7:0] HACK_DOWN      = 8'd133;
    localparam logic [7:0] HACK_HOME      = 8'd134;
    localparam logic [7:0] HACK_END       = 8'd135;
    localparam logic [7:0] HACK_PGUP      = 8'd136;
    localparam logic [7:0] HACK_PGDN      = 8'd137;
    localparam logic [7:0] HACK_INSERT    = 8'd138;
    localparam logic [7:0] HACK_DELETE    = 8'd139;
    localparam logic [7:0] HACK_ESC       = 8'd140;
    localparam logic [7:0] HACK_F1        = 8'd141;
    localparam logic [7:0] HACK_F2        = 8'd142;
    localparam logic [7:0] HACK_F3        = 8'd143;
    localparam logic [7:0] HACK_F4        = 8'd144;
    localparam logic [7:0] HACK_F5        = 8'd145;
    localparam logic [7:0] HACK_F6        = 8'd146;
    localparam logic [7:0] HACK_F7        = 8'd147;
    localparam logic [7:0] HACK_F8        = 8'd148;
    localparam logic [7:0] HACK_F9        = 8'd149;
    localparam logic [7:0] HACK_F10       = 8'd150;
    localparam logic [7:0] HACK_F11       = 8'd151;
    localparam logic [7:0] HACK_F12       = 8'd152;

    // Scan set 2 prefixes and shift keys
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Data + parity must have odd weight, and the stop bit must be 1
    function automatic logic frame_ok(
        input logic [7:0] data,
        input logic       par,
        input logic       stop
    );
        return (^{data, par}) & stop;
    endfunction

endpackage

// File: rtl/ps2_scan_to_hack.sv
// Combinational scan set 2 -> Hack key code map.
// In: ext (E0-prefixed), scan byte, shift. Out: code, 0 = unmapped.
module ps2_scan_to_hack
    import hack_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] scan,
    input  logic       shift,
    output logic [7:0] code
);

    // {valid, index} for letters a..z and digits 0..9
    logic [5:0] ltr;
    logic [4:0] dig;
    logic [7:0] sym;

    always_comb begin
        ltr = 6'd0;
        unique case (scan)
            8'h1C: ltr = 6'd32;
            8'h32: ltr = 6'd33;
            8'h21: ltr = 6'd34;
            8'h23: ltr = 6'd35;
            8'h24: ltr = 6'd36;
            8'h2B: ltr = 6'd37;
            8'h34: ltr = 6'd38;
            8'h33: ltr = 6'd39;
            8'h43: ltr = 6'd40;
            8'h3B: ltr = 6'd41;
            8'h42: ltr = 6'd42;
            8'h4B: ltr = 6'd43;
            8'h3A: ltr = 6'd44;
            8'h31: ltr = 6'd45;
            8'h44: ltr = 6'd46;
            8'h4D: ltr = 6'd47;
            8'h15: ltr = 6'd48;
            8'h2D: ltr = 6'd49;
            8'h1B: ltr = 6'd50;
            8'h2C: ltr = 6'd51;
            8'h3C: ltr = 6'd52;
            8'h2A: ltr = 6'd53;
            8'h1D: ltr = 6'd54;
            8'h22: ltr = 6'd55;
            8'h35: ltr = 6'd56;
            8'h1A: ltr = 6'd57;
            default: ltr = 6'd0;
        endcase
    end

    always_comb begin
        dig = 5'd0;
        unique case (scan)
            8'h45: dig = 5'h10;
            8'h16: dig = 5'h11;
            8'h1E: dig = 5'h12;
            8'h26: dig = 5'h13;
            8'h25: dig = 5'h14;
            8'h2E: dig = 5'h15;
            8'h36: dig = 5'h16;
            8'h3D: dig = 5'h17;
            8'h3E: dig = 5'h18;
            8'h46: dig = 5'h19;
            default: dig = 5'h00;
        endcase
    end

    // US layout symbols on shifted digits
    always_comb begin
        sym = 8'd0;
        unique case (dig[3:0])
            4'd0: sym = 8'd41;
            4'd1: sym = 8'd33;
            4'd2: sym = 8'd64;
            4'd3: sym = 8'd35;
            4'd4: sym = 8'd36;
            4'd5: sym = 8'd37;
            4'd6: sym = 8'd94;
            4'd7: sym = 8'd38;
            4'd8: sym = 8'd42;
            4'd9: sym = 8'd40;
            default: sym = 8'd0;
        endcase
    end

    always_comb begin
        code = 8'd0;
        if (!ext && ltr[5]) begin
            code = (shift ? 8'd65 : 8'd97) + {3'b000, ltr[4:0]};
        end else if (!ext && dig[4]) begin
            code = shift ? sym : 8'd48 + {4'b0000, dig[3:0]};
        end else begin
            unique case ({ext, scan})
                9'h029: code = HACK_SPACE;
                9'h05A: code = HACK_NEWLINE;
                9'h066: code = HACK_BACKSPACE;
                9'h076: code = HACK_ESC;
                9'h005: code = HACK_F1;
                9'h006: code = HACK_F2;
                9'h004: code = HACK_F3;
                9'h00C: code = HACK_F4;
                9'h003: code = HACK_F5;
                9'h00B: code = HACK_F6;
                9'h083: code = HACK_F7;
                9'h00A: code = HACK_F8;
                9'h001: code = HACK_F9;
                9'h009: code = HACK_F10;
                9'h078: code = HACK_F11;
                9'h007: code = HACK_F12;
                9'h16B: code = HACK_LEFT;
                9'h175: code = HACK_UP;
                9'h174: code = HACK_RIGHT;
                9'h172: code = HACK_DOWN;
                9'h16C: code = HACK_HOME;
                9'h169: code = HACK_END;
                9'h17D: code = HACK_PGUP;
                9'h17A: code = HACK_PGDN;
                9'h170: code = HACK_INSERT;
                9'h171: code = HACK_DELETE;
                default: code = 8'd0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_hack_keyboard.sv
// PS/2 keyboard receiver + scan set 2 decoder feeding the Hack KBD register.
// Ports: CLK, reset (async high), ps2_clk/ps2_data (raw), kbd_out[15:0], frame_err pulse.
module ps2_hack_keyboard
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbd_out,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    // Synchronizers reset to the idle bus level so no edge is
    // seen when reset drops with the bus idle.
    logic clk_s1, clk_s2, dat_s1, dat_s2;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter on ps2_clk
    logic [FW-1:0] flt_cnt;
    logic          flt_lvl;
    logic          flt_flip;
    logic          strobe;

    assign flt_flip = (clk_s2 != flt_lvl) && (flt_cnt == FLT_MAX);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            flt_cnt <= '0;
            flt_lvl <= 1'b1;
            strobe  <= 1'b0;
        end else begin
            strobe <= flt_flip & flt_lvl;
            if (clk_s2 == flt_lvl) begin
                flt_cnt <= '0;
            end else if (flt_flip) begin
                flt_lvl <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // RX FSM
    rx_state_t     state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_q, par_n;
    logic          byte_valid, bv_n;
    logic          err_n;
    logic [TW-1:0] to_cnt;
    logic          to_hit;

    assign to_hit = (state != IDLE) && (to_cnt == TO_MAX);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_q      <= par_n;
            byte_valid <= bv_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_q;
        bv_n      = 1'b0;
        err_n     = 1'b0;
        if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    bv_n    = frame_ok(shreg, par_q, dat_s2);
                    err_n   = ~bv_n;
                    state_n = IDLE;
                end
            endcase
        end else if (to_hit) begin
            // stalled frame: drop the partial byte
            state_n = IDLE;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == IDLE || strobe || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Decoder: shreg holds the received byte while byte_valid is high
    logic       ext_f, brk_f, lshift, rshift;
    logic [8:0] held;
    logic [8:0] key;
    logic [7:0] map_code;

    assign key = {ext_f, shreg};

    ps2_scan_to_hack u_map (
        .ext   (ext_f),
        .scan  (shreg),
        .shift (lshift | rshift),
        .code  (map_code)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ext_f   <= 1'b0;
            brk_f   <= 1'b0;
            lshift  <= 1'b0;
            rshift  <= 1'b0;
            held    <= '0;
            kbd_out <= '0;
        end else if (byte_valid) begin
            if (shreg == SC_EXT) begin
                ext_f <= 1'b1;
            end else if (shreg == SC_BRK) begin
                brk_f <= 1'b1;
            end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
                if (!ext_f && shreg == SC_LSHIFT) begin
                    lshift <= ~brk_f;
                end else if (!ext_f && shreg == SC_RSHIFT) begin
                    rshift <= ~brk_f;
                end else if (brk_f) begin
                    // only releasing the shown key clears it
                    if (key == held) begin
                        kbd_out <= '0;
                        held    <= '0;
                    end
                end else if (map_code != 8'd0) begin
                    kbd_out <= {8'h00, map_code};
                    held    <= key;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_hack_keyboard.sv
// Scoreboard bench for ps2_hack_keyboard.
// Expected kbd_out changes / frame_err pulses are queued and matched as they appear.
`timescale 1ns/1ps
module tb_ps2_hack_keyboard;

    localparam int TO   = 1000;
    localparam int HALF = 40;
    localparam int GAP  = 100;

    typedef struct {
        logic [16:0] val;
        bit          lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kbd_out;
    logic        frame_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stop_cyc = 0;
    bit   mon_on = 0;
    logic [15:0] prev_kbd = '0;
    exp_t q[$];

    always #500 CLK = ~CLK;

    ps2_hack_keyboard #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kbd_out   (kbd_out),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic exp_k(input logic [15:0] v, input bit lat);
        exp_t e;
        e.val = {1'b0, v};
        e.lat = lat;
        q.push_back(e);
    endtask

    task automatic exp_e(input bit lat);
        exp_t e;
        e.val = 17'h10000;
        e.lat = lat;
        q.push_back(e);
    endtask

    task automatic handle(input logic [16:0] obs);
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected", {15'b0, obs}, 32'h1FFFF);
        end else begin
            e = q.pop_front();
            chk("event", {15'b0, obs}, {15'b0, e.val});
            if (e.lat)
                chk("latency", {31'b0, (cyc - stop_cyc) <= 12}, 32'd1);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (mon_on) begin
                if (frame_err) handle(17'h10000);
                if (kbd_out !== prev_kbd) handle({1'b0, kbd_out});
                prev_kbd = kbd_out;
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(negedge CLK);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge CLK);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
        repeat (GAP) @(negedge CLK);
    endtask

    initial begin
        #100 reset = 1'b1;
        #1;
        chk("rst_kbd", {16'b0, kbd_out}, 32'h0);
        chk("rst_err", {31'b0, frame_err}, 32'h0);
        repeat (5) @(negedge CLK);
        reset = 1'b0;
        repeat (20) @(negedge CLK);
        prev_kbd = kbd_out;
        mon_on = 1;

        // 1: press/release a, then a, b, release a
        exp_k(16'h0061, 1); send(8'h1C);
        send(8'hF0);
        exp_k(16'h0000, 1); send(8'h1C);
        exp_k(16'h0061, 1); send(8'h1C);
        exp_k(16'h0062, 1); send(8'h32);
        send(8'hF0); send(8'h1C);
        chk("t1_hold", {16'b0, kbd_out}, 32'h62);
        send(8'hF0); exp_k(16'h0000, 1); send(8'h32);

        // 2: shift
        send(8'h12);
        exp_k(16'h0041, 1); send(8'h1C);
        send(8'hF0); exp_k(16'h0000, 1); send(8'h1C);
        send(8'hF0); send(8'h12);
        exp_k(16'h0061, 1); send(8'h1C);
        send(8'hF0); exp_k(16'h0000, 1); send(8'h1C);

        // 3: extended and special keys
        send(8'hE0); exp_k(16'h0083, 1); send(8'h75);
        send(8'hE0); send(8'hF0); exp_k(16'h0000, 1); send(8'h75);
        exp_k(16'h0080, 1); send(8'h5A);
        exp_k(16'h008C, 1); send(8'h76);
        chk("t3_esc", {16'b0, kbd_out}, 32'h8C);
        send(8'hF0); exp_k(16'h0000, 1); send(8'h76);

        // shifted digit and F12
        send(8'h59);
        exp_k(16'h0040, 1); send(8'h1E);
        send(8'hF0); exp_k(16'h0000, 1); send(8'h1E);
        send(8'hF0); send(8'h59);
        exp_k(16'h0098, 1); send(8'h07);
        send(8'hF0); exp_k(16'h0000, 1); send(8'h07);

        // 4: bad parity, bad stop
        exp_e(1); send_frame(8'h1C, 1'b1, 1'b0, 11);
        repeat (GAP) @(negedge CLK);
        exp_e(1); send_frame(8'h1C, 1'b0, 1'b1, 11);
        repeat (GAP) @(negedge CLK);
        chk("t4_kbd", {16'b0, kbd_out}, 32'h0);

        // 5: stalled frame times out once
        exp_e(0); send_frame(8'h00, 1'b0, 1'b0, 4);
        repeat (TO + 50) @(negedge CLK);
        chk("t5_pend", q.size(), 32'd0);
        exp_k(16'h0081, 1); send(8'h66);
        send(8'hF0); exp_k(16'h0000, 1); send(8'h66);
        exp_k(16'h0061, 1); send(8'h1C);

        // 6: typematic repeat, then reset mid-frame
        send(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0, 5);
        exp_k(16'h0000, 0);
        #100 reset = 1'b1;
        #100;
        chk("t6_kbd", {16'b0, kbd_out}, 32'h0);
        chk("t6_err", {31'b0, frame_err}, 32'h0);
        repeat (5) @(negedge CLK);
        reset = 1'b0;
        repeat (20) @(negedge CLK);
        exp_k(16'h0061, 1); send(8'h1C);
        chk("t6_after", {16'b0, kbd_out}, 32'h61);

        repeat (GAP) @(negedge CLK);
        chk("pending", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
